// File: rtl/score_pkg.sv
// Shared defaults and handshake state encoding for the score request controller.
package score_pkg;

  localparam int unsigned DEBOUNCE_CYCLES_DEF = 16;
  localparam int unsigned PEND_W_DEF          = 4;
  localparam int unsigned TIMEOUT_CYCLES_DEF  = 1048576;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REQ      = 2'd1,
    ST_ACK_WAIT = 2'd2
  } req_state_e;

endpackage

// File: rtl/prize_debouncer.sv
// Two-flop synchronizer plus stability-counter debounce for the prize chute sensor.
// rise_o pulses for one cycle right after the debounced level goes 0->1.
module prize_debouncer
  import score_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic sensor_i,
  output logic rise_o
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Count consecutive mismatching samples; flip the level on the last one.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    rise_d  = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        level_d = sync2_q;
        rise_d  = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Synchronizer, debounce state and rise pulse registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sensor_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      rise_q  <= rise_d;
      cnt_q   <= cnt_d;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/score_request_ctrl.sv
// Turns debounced prize events into four-phase score-increment requests,
// queuing unacknowledged events in a saturating pending counter.
module score_request_ctrl
  import score_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned PEND_W          = PEND_W_DEF,
  parameter int unsigned TIMEOUT_CYCLES  = TIMEOUT_CYCLES_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              prize_sensor,
  input  logic              game_enable,
  output logic              need_to_increment_score,
  input  logic              finished_incrementing_score,
  output logic [PEND_W-1:0] pending_count,
  output logic              overflow,
  output logic              timeout_err
);

  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  req_state_e        state_q, state_d;
  logic              need_q, need_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic              ovf_q, ovf_d;
  logic [TO_W-1:0]   tcnt_q, tcnt_d;
  logic              terr_q, terr_d;
  logic              rise;
  logic              event_c;
  logic              complete_c;

  prize_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clock   (clock),
    .reset   (reset),
    .sensor_i(prize_sensor),
    .rise_o  (rise)
  );

  // Enable only gates new events; a completion is the REQ->ACK_WAIT edge.
  assign event_c    = rise & game_enable;
  assign complete_c = (state_q == ST_REQ) && finished_incrementing_score;

  // Handshake next-state; need follows the state it will be in.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:     if (pend_q != '0) state_d = ST_REQ;
      ST_REQ:      if (finished_incrementing_score) state_d = ST_ACK_WAIT;
      ST_ACK_WAIT: if (!finished_incrementing_score) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
    need_d = (state_d == ST_REQ);
  end

  // Pending counter with saturation and sticky overflow.
  always_comb begin
    pend_d = pend_q;
    ovf_d  = ovf_q;
    if (event_c && !complete_c) begin
      if (pend_q == PEND_MAX) begin
        ovf_d = 1'b1;
      end else begin
        pend_d = pend_q + PEND_W'(1);
      end
    end else if (complete_c && !event_c) begin
      pend_d = pend_q - PEND_W'(1);
    end
  end

  // Saturating REQ dwell counter; timeout flag is sticky and does not move the FSM.
  always_comb begin
    tcnt_d = '0;
    terr_d = terr_q;
    if (state_q == ST_REQ) begin
      if (tcnt_q != TO_W'(TIMEOUT_CYCLES)) begin
        tcnt_d = tcnt_q + TO_W'(1);
      end else begin
        tcnt_d = tcnt_q;
      end
      if (tcnt_d == TO_W'(TIMEOUT_CYCLES)) terr_d = 1'b1;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      need_q  <= 1'b0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
      tcnt_q  <= '0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      need_q  <= need_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      tcnt_q  <= tcnt_d;
      terr_q  <= terr_d;
    end
  end

  assign need_to_increment_score = need_q;
  assign pending_count           = pend_q;
  assign overflow                = ovf_q;
  assign timeout_err             = terr_q;

endmodule

// File: tb/tb_score_request_ctrl.sv
// Directed bench for score_request_ctrl with a cycle-level reference model.
module tb_score_request_ctrl;

  localparam int unsigned DEB = 4;
  localparam int unsigned PW  = 2;
  localparam int unsigned TO  = 20;
  localparam int          PMAX = 3;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          prize_sensor = 1'b0;
  logic          game_enable = 1'b0;
  logic          finished = 1'b0;
  logic          need;
  logic [PW-1:0] pend;
  logic          ovf;
  logic          terr;

  int checks = 0;
  int errors = 0;
  int rises  = 0;
  int score  = 0;

  always #5 clock = ~clock;

  score_request_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .PEND_W         (PW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clock                      (clock),
    .reset                      (reset),
    .prize_sensor               (prize_sensor),
    .game_enable                (game_enable),
    .need_to_increment_score    (need),
    .finished_incrementing_score(finished),
    .pending_count              (pend),
    .overflow                   (ovf),
    .timeout_err                (terr)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs as seen at the most recent rising edge.
  bit s_reset = 1'b1, s_sens = 1'b0, s_en = 1'b0, s_fin = 1'b0;
  initial forever begin
    @(posedge clock);
    s_reset = reset;
    s_sens  = prize_sensor;
    s_en    = game_enable;
    s_fin   = finished;
  end

  // Reference model: raw sensor delayed two samples, level flips once the last
  // DEB samples all disagree with it, events are queued as an integer count.
  bit m_sh0, m_sh1, m_lvl, m_rise, m_need, m_drain, m_ovf, m_terr;
  bit m_hist[$];
  int m_pend, m_tcyc;

  task automatic model_step();
    bit synced, ev, comp, all_diff;
    int pend_before;
    if (s_reset) begin
      m_sh0 = 0; m_sh1 = 0; m_lvl = 0; m_rise = 0; m_need = 0; m_drain = 0;
      m_ovf = 0; m_terr = 0; m_pend = 0; m_tcyc = 0; m_hist.delete();
      return;
    end
    synced = m_sh1;
    m_sh1  = m_sh0;
    m_sh0  = s_sens;
    ev     = m_rise && s_en;
    m_rise = 0;
    m_hist.push_back(synced);
    if (m_hist.size() > DEB) void'(m_hist.pop_front());
    all_diff = (m_hist.size() == DEB);
    foreach (m_hist[i]) if (m_hist[i] == m_lvl) all_diff = 0;
    if (all_diff) begin
      m_lvl  = ~m_lvl;
      m_rise = m_lvl;
      m_hist.delete();
    end
    comp = m_need && s_fin;
    if (m_need) begin
      if (m_tcyc < TO) m_tcyc++;
      if (m_tcyc == TO) m_terr = 1;
    end else begin
      m_tcyc = 0;
    end
    pend_before = m_pend;
    if (ev && !comp) begin
      if (m_pend == PMAX) m_ovf = 1;
      else m_pend++;
    end else if (comp && !ev) begin
      m_pend--;
    end
    if (m_need) begin
      if (s_fin) begin m_need = 0; m_drain = 1; end
    end else if (m_drain) begin
      if (!s_fin) m_drain = 0;
    end else if (pend_before != 0) begin
      m_need = 1;
    end
  endtask

  // Every-cycle comparison against the model, plus need rising-edge count.
  bit need_prev = 1'b0;
  initial forever begin
    @(negedge clock);
    model_step();
    chk("cyc_need", int'(need), int'(m_need));
    chk("cyc_pend", int'(pend), m_pend);
    chk("cyc_ovf", int'(ovf), int'(m_ovf));
    chk("cyc_terr", int'(terr), int'(m_terr));
    if (need && !need_prev) rises++;
    need_prev = need;
  end

  task automatic step(input int n);
    repeat (n) @(negedge clock);
    #1;
  endtask

  task automatic wait_need(input bit val, input int budget, input string name);
    int n = 0;
    while (need != val && n < budget) begin
      step(1);
      n++;
    end
    chk(name, int'(need), int'(val));
  endtask

  task automatic handshake(input int delay);
    wait_need(1'b1, 40, "hs_need_rise");
    step(delay);
    finished = 1'b1;
    wait_need(1'b0, 10, "hs_need_drop");
    if (!need) score++;
    finished = 1'b0;
    step(1);
  endtask

  task automatic do_reset();
    reset = 1'b1; prize_sensor = 1'b0; finished = 1'b0;
    step(3);
    chk("rst_need", int'(need), 0);
    chk("rst_pend", int'(pend), 0);
    chk("rst_ovf", int'(ovf), 0);
    chk("rst_terr", int'(terr), 0);
    reset = 1'b0;
    step(1);
  endtask

  task automatic pulse(input int hi, input int lo);
    prize_sensor = 1'b1;
    step(hi);
    prize_sensor = 1'b0;
    step(lo);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1);
  end

  initial begin
    int r0;
    step(1);

    // Single event, ack three cycles after need.
    do_reset();
    game_enable = 1'b1;
    r0 = rises; score = 0;
    fork
      begin prize_sensor = 1'b1; step(10); prize_sensor = 1'b0; end
      begin
        step(7);
        chk("t1_pend_after_event", int'(pend), 1);
        chk("t1_need_before", int'(need), 0);
        step(1);
        chk("t1_need_latency", int'(need), 1);
        step(3);
        finished = 1'b1;
        wait_need(1'b0, 10, "t1_need_drop");
        if (!need) score++;
        finished = 1'b0;
      end
    join
    step(12);
    chk("t1_pend_final", int'(pend), 0);
    chk("t1_need_pulses", rises - r0, 1);
    chk("t1_score", score, 1);

    // Three-cycle glitch is filtered.
    do_reset();
    r0 = rises;
    pulse(3, 12);
    chk("t2_pend", int'(pend), 0);
    chk("t2_no_need", rises - r0, 0);

    // Four events without ack saturate; enable drop does not cancel them.
    do_reset();
    repeat (4) pulse(6, 6);
    chk("t3_pend_sat", int'(pend), 3);
    chk("t3_ovf", int'(ovf), 1);
    game_enable = 1'b0;
    repeat (3) handshake(1);
    step(4);
    chk("t3_pend_drained", int'(pend), 0);
    chk("t3_need_low", int'(need), 0);
    game_enable = 1'b1;

    // Event on the same edge as a completion at pending=2.
    do_reset();
    pulse(6, 6);
    pulse(6, 6);
    chk("t4_pend_two", int'(pend), 2);
    prize_sensor = 1'b1;
    step(6);
    finished = 1'b1;
    step(1);
    chk("t4_pend_coincide", int'(pend), 2);
    finished = 1'b0;
    prize_sensor = 1'b0;
    repeat (2) handshake(1);
    step(4);
    chk("t4_pend_drained", int'(pend), 0);

    // Timeout after 20 cycles in REQ, later ack completes.
    do_reset();
    prize_sensor = 1'b1;
    step(8);
    chk("t5_need", int'(need), 1);
    prize_sensor = 1'b0;
    step(19);
    chk("t5_terr_early", int'(terr), 0);
    step(1);
    chk("t5_terr_set", int'(terr), 1);
    chk("t5_need_held", int'(need), 1);
    handshake(2);
    step(3);
    chk("t5_pend_after", int'(pend), 0);
    chk("t5_terr_sticky", int'(terr), 1);

    // Reset in REQ with pending=2.
    do_reset();
    pulse(6, 6);
    pulse(6, 6);
    step(10);
    chk("t6_pend_two", int'(pend), 2);
    chk("t6_terr_pre", int'(terr), 1);
    reset = 1'b1;
    step(1);
    chk("t6_need_cleared", int'(need), 0);
    chk("t6_pend_cleared", int'(pend), 0);
    chk("t6_terr_cleared", int'(terr), 0);
    chk("t6_ovf_cleared", int'(ovf), 0);
    reset = 1'b0;
    step(2);

    // Disabled transitions make no event; ack while idle is ignored.
    do_reset();
    game_enable = 1'b0;
    pulse(6, 8);
    chk("t7_disabled_pend", int'(pend), 0);
    finished = 1'b1;
    step(4);
    finished = 1'b0;
    step(2);
    chk("t7_idle_ack_pend", int'(pend), 0);
    chk("t7_idle_ack_need", int'(need), 0);

    // Sensor held high across reset release gives exactly one event.
    reset = 1'b1; prize_sensor = 1'b1; game_enable = 1'b1;
    step(3);
    reset = 1'b0;
    step(6);
    chk("t8_pend_before", int'(pend), 0);
    step(1);
    chk("t8_pend_event", int'(pend), 1);
    handshake(0);
    step(10);
    chk("t8_pend_final", int'(pend), 0);
    prize_sensor = 1'b0;
    step(10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
